// File: rtl/dvp_capture.sv
// Parallel camera (DVP) capture: frames registered pad samples, packs bytes
// into words tagged with SOF/EOL, and buffers them in a FWFT output FIFO.
module dvp_capture #(
   parameter int DATA_W         = 8,
   parameter int BYTES_PER_WORD = 2,
   parameter int LINE_W         = 12,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             capture_en,
   input  logic                             cam_valid,
   input  logic                             cam_vsync,
   input  logic                             cam_href,
   input  logic [DATA_W-1:0]                cam_data,
   output logic [DATA_W*BYTES_PER_WORD-1:0] m_data,
   output logic                             m_sof,
   output logic                             m_eol,
   output logic                             m_valid,
   input  logic                             m_ready,
   output logic                             frame_done,
   output logic                             busy,
   output logic [LINE_W-1:0]                line_count,
   output logic [15:0]                      frame_count,
   output logic                             overflow,
   output logic                             short_line,
   input  logic                             clear_status
);

   localparam int WORD_W = DATA_W * BYTES_PER_WORD;
   localparam int IDX_W  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_VSYNC, S_FRAME} state_t;

   state_t              r_state, w_state_next;
   logic [IDX_W-1:0]    r_idx;
   logic [WORD_W-1:0]   r_word;
   logic [WORD_W-1:0]   r_pend_data;
   logic                r_pend_valid;
   logic                r_prev_href;
   logic                r_sof_pending;
   logic [LINE_W-1:0]   r_lines;
   logic [LINE_W-1:0]   r_line_count;
   logic [15:0]         r_frame_count;
   logic                r_frame_done;
   logic                r_overflow;
   logic                r_short_line;

   logic                r_push_valid;
   logic [WORD_W-1:0]   r_push_data;
   logic                r_push_sof;
   logic                r_push_eol;

   logic [WORD_W+1:0]   r_mem [FIFO_DEPTH];
   logic [PTR_W:0]      r_wr_ptr;
   logic [PTR_W:0]      r_rd_ptr;

   logic                w_sample, w_end, w_byte, w_fall, w_enter_frame;
   logic [WORD_W-1:0]   w_word_new;
   logic [LINE_W-1:0]   w_lines_inc, w_lines_fin;
   logic                w_iss_valid;
   logic [WORD_W-1:0]   w_iss_data;
   logic                w_iss_eol;
   logic [PTR_W:0]      w_count;
   logic                w_full, w_pop, w_accept, w_drop, w_short_err;

   // ---------------- state machine ----------------
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (cam_valid) begin
         case (r_state)
            S_IDLE:  if (capture_en) w_state_next = S_ARM;
            S_ARM:   if (cam_vsync) w_state_next = S_VSYNC;
            S_VSYNC: if (!cam_vsync) w_state_next = S_FRAME;
            S_FRAME: if (cam_vsync) w_state_next = capture_en ? S_VSYNC : S_IDLE;
            default: w_state_next = S_IDLE;
         endcase
      end
   end

   assign w_sample      = cam_valid && (r_state == S_FRAME);
   assign w_end         = w_sample && cam_vsync;
   assign w_byte        = w_sample && !cam_vsync && cam_href;
   assign w_fall        = w_sample && r_prev_href && (cam_vsync || !cam_href);
   assign w_enter_frame = cam_valid && (r_state == S_VSYNC) && !cam_vsync;

   generate
      for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_slot
         assign w_word_new[WORD_W-1-gi*DATA_W -: DATA_W] =
            (r_idx == IDX_W'(gi)) ? cam_data : r_word[WORD_W-1-gi*DATA_W -: DATA_W];
      end
   endgenerate

   assign w_lines_inc = (r_lines == '1) ? r_lines : r_lines + 1'b1;
   assign w_lines_fin = w_fall ? w_lines_inc : r_lines;
   assign w_short_err = w_fall && (r_idx != '0);

   // A partial word can only exist after its line's pending word was already
   // pushed by the byte that started it, so a line end issues a single push.
   always_comb begin
      w_iss_valid = 1'b0;
      w_iss_data  = r_pend_data;
      w_iss_eol   = 1'b0;
      if (w_byte) begin
         w_iss_valid = r_pend_valid;
      end else if (w_fall) begin
         w_iss_eol = 1'b1;
         if (r_idx != '0) begin
            w_iss_valid = 1'b1;
            w_iss_data  = r_word;
         end else begin
            w_iss_valid = r_pend_valid;
         end
      end
   end

   // ---------------- framing / packing datapath ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_idx         <= '0;
         r_word        <= '0;
         r_pend_data   <= '0;
         r_pend_valid  <= 1'b0;
         r_prev_href   <= 1'b0;
         r_sof_pending <= 1'b0;
         r_lines       <= '0;
         r_line_count  <= '0;
         r_frame_count <= '0;
         r_frame_done  <= 1'b0;
         r_push_valid  <= 1'b0;
         r_push_data   <= '0;
         r_push_sof    <= 1'b0;
         r_push_eol    <= 1'b0;
      end else begin
         r_push_valid <= w_iss_valid;
         r_push_data  <= w_iss_data;
         r_push_eol   <= w_iss_eol;
         r_push_sof   <= r_sof_pending;
         if (w_iss_valid) r_sof_pending <= 1'b0;

         if (w_enter_frame) begin
            r_sof_pending <= 1'b1;
            r_lines       <= '0;
            r_idx         <= '0;
            r_word        <= '0;
            r_pend_valid  <= 1'b0;
            r_prev_href   <= 1'b0;
         end

         if (w_sample) r_prev_href <= cam_href && !cam_vsync;

         if (w_byte) begin
            if (r_idx == LAST_IDX) begin
               r_pend_data  <= w_word_new;
               r_pend_valid <= 1'b1;
               r_idx        <= '0;
               r_word       <= '0;
            end else begin
               r_word       <= w_word_new;
               r_idx        <= r_idx + 1'b1;
               r_pend_valid <= 1'b0;
            end
         end else if (w_fall) begin
            r_pend_valid <= 1'b0;
            r_idx        <= '0;
            r_word       <= '0;
            r_lines      <= w_lines_inc;
         end

         r_frame_done <= w_end;
         if (w_end) begin
            r_line_count  <= w_lines_fin;
            r_frame_count <= r_frame_count + 16'd1;
         end
      end
   end

   // ---------------- output FIFO (first-word-fall-through) ----------------
   assign w_count  = r_wr_ptr - r_rd_ptr;
   assign w_full   = (w_count == (PTR_W+1)'(FIFO_DEPTH));
   assign w_pop    = m_valid && m_ready;
   assign w_accept = r_push_valid && (!w_full || w_pop);
   assign w_drop   = r_push_valid && w_full && !w_pop;

   always_ff @(posedge clk) begin
      if (w_accept) r_mem[r_wr_ptr[PTR_W-1:0]] <= {r_push_sof, r_push_eol, r_push_data};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_overflow   <= 1'b0;
         r_short_line <= 1'b0;
      end else begin
         if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
         // A new error in the same cycle as clear_status keeps the flag set.
         if (w_drop)            r_overflow <= 1'b1;
         else if (clear_status) r_overflow <= 1'b0;
         if (w_short_err)       r_short_line <= 1'b1;
         else if (clear_status) r_short_line <= 1'b0;
      end
   end

   logic [WORD_W+1:0] w_head;
   assign w_head      = r_mem[r_rd_ptr[PTR_W-1:0]];
   assign m_valid     = (r_wr_ptr != r_rd_ptr);
   assign m_data      = m_valid ? w_head[WORD_W-1:0] : '0;
   assign m_eol       = m_valid && w_head[WORD_W];
   assign m_sof       = m_valid && w_head[WORD_W+1];
   assign frame_done  = r_frame_done;
   assign busy        = (r_state == S_FRAME);
   assign line_count  = r_line_count;
   assign frame_count = r_frame_count;
   assign overflow    = r_overflow;
   assign short_line  = r_short_line;

endmodule
